// File: rtl/rv32e_bus_arb.sv
// Round-robin arbiter sharing one 32-bit bus slave between NM requesters.
// Optional slave-response timeout is enabled by defining ARB_TIMEOUT_EN.
module rv32e_bus_arb #(
    parameter int NM      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rstb,
    input  logic [NM-1:0]      m_valid,
    input  logic [NM-1:0]      m_write,
    input  logic [32*NM-1:0]   m_addr,
    input  logic [32*NM-1:0]   m_wdata,
    input  logic [2*NM-1:0]    m_size,
    output logic [NM-1:0]      m_ready,
    output logic [31:0]        m_rdata,
    output logic               s_valid,
    output logic               s_write,
    output logic [31:0]        s_addr,
    output logic [31:0]        s_wdata,
    output logic [1:0]         s_size,
    input  logic               s_ready,
    input  logic [31:0]        s_rdata,
    output logic [NM-1:0]      grant,
    output logic               busy,
    output logic               err
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] owner;
    logic [IW-1:0] sel;
    logic          any_req;
    logic          to_hit;
    logic          done;

    // Walk from the lowest priority (last) to the highest (last+1) so the
    // final match is the round-robin winner.
    always_comb begin
        sel     = last;
        any_req = 1'b0;
        for (int i = NM; i >= 1; i--) begin
            if (m_valid[(int'(last) + i) % NM]) begin
                any_req = 1'b1;
                sel     = IW'((int'(last) + i) % NM);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign to_hit = busy && !s_ready && (to_cnt == 16'(TIMEOUT));

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == IDLE)
                to_cnt <= '0;
            else if (!s_ready && !to_hit)
                to_cnt <= to_cnt + 16'd1;
            if (to_hit)
                err <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    assign done    = busy & (s_ready | to_hit);
    assign m_ready = grant & {NM{done}};
    assign m_rdata = to_hit ? 32'hDEAD_BEEF : s_rdata;

    // A completion always passes through IDLE, so a requester that drops
    // valid on its m_ready edge cannot be re-granted on a stale request.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state   <= IDLE;
            last    <= IW'(NM - 1);
            owner   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            s_valid <= 1'b0;
            s_write <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_size  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant   <= NM'(1) << sel;
                        owner   <= sel;
                        s_write <= m_write[sel];
                        s_addr  <= m_addr[32*int'(sel) +: 32];
                        s_wdata <= m_wdata[32*int'(sel) +: 32];
                        s_size  <= m_size[2*int'(sel) +: 2];
                        s_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= BUSY;
                    end else begin
                        s_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        s_valid <= 1'b0;
                        grant   <= '0;
                        busy    <= 1'b0;
                        last    <= owner;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32e_bus_arb.sv
// Self-checking bench for rv32e_bus_arb (NM=2): table-driven transactions with
// a scoreboard queue, plus hand sequences for reset, back-to-back and timeout.
module tb_rv32e_bus_arb;

    localparam int NM = 2;

    logic          clk = 1'b0;
    logic          rstb;
    logic [1:0]    m_valid, m_write, m_ready;
    logic [63:0]   m_addr, m_wdata;
    logic [3:0]    m_size;
    logic [31:0]   m_rdata;
    logic          s_valid, s_write, s_ready;
    logic [31:0]   s_addr, s_wdata, s_rdata;
    logic [1:0]    s_size, grant;
    logic          busy, err;

    always #5 clk = ~clk;

    rv32e_bus_arb #(.NM(NM), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rstb(rstb),
        .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_size(m_size), .m_ready(m_ready), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_size(s_size), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .busy(busy), .err(err)
    );

    typedef struct {
        logic [1:0]  mask;
        logic [1:0]  wr;
        logic [31:0] a0, a1, d0, d1;
        logic [1:0]  z0, z1;
        int          dly;
        logic [31:0] rd;
        int          win;
    } vec_t;

    typedef struct {
        logic [31:0] addr, wdata, rd;
        logic        wr;
        logic [1:0]  sz, gnt;
    } exp_t;

    vec_t vt[7];
    exp_t sbq[$];
    exp_t e;
    int   npass = 0;
    int   ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            mask   wr     a0        a1        d0            d1            z0     z1     dly rd            win
        vt[0] = '{2'b01, 2'b00, 32'h100, 32'h000, 32'h0,        32'h0,        2'b10, 2'b00, 2, 32'h12345678, 0};
        vt[1] = '{2'b10, 2'b10, 32'h000, 32'h200, 32'h0,        32'hCAFEBABE, 2'b00, 2'b10, 5, 32'h0,        1};
        vt[2] = '{2'b11, 2'b01, 32'h300, 32'h304, 32'h11112222, 32'h33334444, 2'b00, 2'b01, 0, 32'hA5A5A5A5, 0};
        vt[3] = '{2'b11, 2'b10, 32'h308, 32'h30C, 32'h55556666, 32'h77778888, 2'b01, 2'b10, 1, 32'h0F0F0F0F, 1};
        vt[4] = '{2'b11, 2'b00, 32'h400, 32'h404, 32'h1,        32'h2,        2'b10, 2'b10, 0, 32'h00000001, 0};
        vt[5] = '{2'b01, 2'b01, 32'h500, 32'h504, 32'h3,        32'h4,        2'b00, 2'b00, 0, 32'h00000002, 0};
        vt[6] = '{2'b11, 2'b11, 32'h600, 32'h604, 32'h5,        32'h6,        2'b01, 2'b10, 3, 32'h00000003, 1};

        rstb = 1'b0; m_valid = '0; m_write = '0; m_addr = '0; m_wdata = '0; m_size = '0;
        s_ready = 1'b0; s_rdata = '0;
        tick; tick;
        chk("rst_s_valid", s_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_s_addr", s_addr, 0);
        rstb = 1'b1;
        tick;
        chk("idle_s_valid", s_valid, 0);

        foreach (vt[n]) begin
            m_valid = vt[n].mask;
            m_write = vt[n].wr;
            m_addr  = {vt[n].a1, vt[n].a0};
            m_wdata = {vt[n].d1, vt[n].d0};
            m_size  = {vt[n].z1, vt[n].z0};
            e.addr  = (vt[n].win == 0) ? vt[n].a0 : vt[n].a1;
            e.wdata = (vt[n].win == 0) ? vt[n].d0 : vt[n].d1;
            e.sz    = (vt[n].win == 0) ? vt[n].z0 : vt[n].z1;
            e.wr    = vt[n].wr[vt[n].win];
            e.gnt   = 2'b01 << vt[n].win;
            e.rd    = vt[n].rd;
            sbq.push_back(e);
            tick;
            chk($sformatf("v%0d_s_valid", n), s_valid, 1);
            if (sbq.size() == 0) begin
                ntot++;
                $display("FAIL v%0d_scoreboard: got empty queue, want entry", n);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("v%0d_s_addr", n), s_addr, e.addr);
                chk($sformatf("v%0d_s_wdata", n), s_wdata, e.wdata);
                chk($sformatf("v%0d_s_write", n), s_write, e.wr);
                chk($sformatf("v%0d_s_size", n), s_size, e.sz);
                chk($sformatf("v%0d_grant", n), grant, e.gnt);
                chk($sformatf("v%0d_busy", n), busy, 1);
                for (int d = 0; d < vt[n].dly; d++) begin
                    tick;
                    chk($sformatf("v%0d_hold_valid", n), s_valid, 1);
                    chk($sformatf("v%0d_hold_addr", n), s_addr, e.addr);
                    chk($sformatf("v%0d_hold_wdata", n), s_wdata, e.wdata);
                    chk($sformatf("v%0d_hold_m_ready", n), m_ready, 0);
                end
                s_ready = 1'b1;
                s_rdata = vt[n].rd;
                #1;
                chk($sformatf("v%0d_m_ready", n), m_ready, e.gnt);
                chk($sformatf("v%0d_m_rdata", n), m_rdata, e.rd);
                m_valid = '0;
                tick;
                s_ready = 1'b0;
                #1;
                chk($sformatf("v%0d_done_s_valid", n), s_valid, 0);
                chk($sformatf("v%0d_done_grant", n), grant, 0);
                chk($sformatf("v%0d_done_busy", n), busy, 0);
                chk($sformatf("v%0d_done_m_ready", n), m_ready, 0);
            end
        end

        // Reset while BUSY, then back-to-back with s_ready tied high
        m_valid = 2'b10; m_write = '0; m_addr = {32'h704, 32'h700}; m_size = '0;
        tick;
        chk("mid_grant", grant, 2'b10);
        tick;
        rstb = 1'b0;
        #1;
        chk("async_rst_s_valid", s_valid, 0);
        chk("async_rst_grant", grant, 0);
        chk("async_rst_busy", busy, 0);
        m_valid = 2'b11;
        s_ready = 1'b1;
        tick;
        rstb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i % 2 == 0) begin
                chk($sformatf("rr%0d_s_valid", i), s_valid, 1);
                chk($sformatf("rr%0d_s_addr", i), s_addr, ((i / 2) % 2 == 0) ? 32'h700 : 32'h704);
                chk($sformatf("rr%0d_m_ready", i), m_ready, ((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
            end else begin
                chk($sformatf("rr%0d_s_valid", i), s_valid, 0);
                chk($sformatf("rr%0d_m_ready", i), m_ready, 0);
            end
        end
        m_valid = '0;
        s_ready = 1'b0;
        tick;
        chk("rr_quiet", s_valid, 0);

        // Granted requester abandons its request mid-BUSY
        m_valid = 2'b01; m_write = 2'b01; m_addr = {32'h0, 32'h800}; m_wdata = {32'h0, 32'hBEEF0001};
        tick;
        chk("drop_grant", grant, 2'b01);
        m_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("drop_hold_valid", s_valid, 1);
            chk("drop_hold_addr", s_addr, 32'h800);
            chk("drop_hold_wdata", s_wdata, 32'hBEEF0001);
        end
        s_ready = 1'b1;
        #1;
        chk("drop_m_ready", m_ready, 2'b01);
        tick;
        s_ready = 1'b0;
        #1;
        chk("drop_done_s_valid", s_valid, 0);
        chk("drop_done_busy", busy, 0);
        tick;
        chk("drop_no_regrant", s_valid, 0);

`ifdef ARB_TIMEOUT_EN
        begin
            int n;
            m_valid = 2'b10; m_write = '0; m_addr = {32'h900, 32'h0};
            tick;
            chk("to_s_valid", s_valid, 1);
            n = 0;
            while (m_ready == 2'b00 && n < 40) begin
                tick;
                n++;
            end
            chk("to_cycles", n, 16);
            chk("to_m_ready", m_ready, 2'b10);
            chk("to_m_rdata", m_rdata, 32'hDEADBEEF);
            m_valid = '0;
            tick;
            chk("to_err_set", err, 1);
            chk("to_busy", busy, 0);
            tick; tick; tick;
            chk("to_err_sticky", err, 1);
            rstb = 1'b0;
            #1;
            chk("to_err_clear", err, 0);
            rstb = 1'b1;
        end
`else
        chk("err_tied_low", err, 0);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
